// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU issue stage.
// Command encodings, issue states and operand-need decode.
package alu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CMD_WIDTH  = 4;

  typedef enum logic {
    MODE_LOGIC = 1'b0,
    MODE_ARITH = 1'b1
  } mode_e;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND    = 4'd0,
    L_NAND   = 4'd1,
    L_OR     = 4'd2,
    L_NOR    = 4'd3,
    L_XOR    = 4'd4,
    L_XNOR   = 4'd5,
    L_NOT_A  = 4'd6,
    L_NOT_B  = 4'd7,
    L_SHR1_A = 4'd8,
    L_SHL1_A = 4'd9,
    L_SHR1_B = 4'd10,
    L_SHL1_B = 4'd11,
    L_ROL    = 4'd12,
    L_ROR    = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_BUSY
  } issue_state_e;

  typedef struct packed {
    logic       invalid;
    logic [1:0] mask;
  } need_t;

  function automatic need_t need_ops(
    input logic       mode,
    input logic [7:0] cmd
  );
    need_t n;
    n.invalid = 1'b0;
    n.mask    = 2'b00;
    if (mode == MODE_ARITH) begin
      if (cmd inside {[8'd0:8'd3], [8'd8:8'd10]})
        n.mask = 2'b11;
      else if (cmd inside {8'd4, 8'd5})
        n.mask = 2'b01;
      else if (cmd inside {8'd6, 8'd7})
        n.mask = 2'b10;
      else
        n.invalid = 1'b1;
    end else begin
      if (cmd inside {[8'd0:8'd5], 8'd12, 8'd13})
        n.mask = 2'b11;
      else if (cmd inside {8'd6, 8'd8, 8'd9})
        n.mask = 2'b01;
      else if (cmd inside {8'd7, 8'd10, 8'd11})
        n.mask = 2'b10;
      else
        n.invalid = 1'b1;
    end
    return n;
  endfunction

  function automatic logic is_mul(
    input logic       mode,
    input logic [7:0] cmd
  );
    return mode && (cmd == 8'd9 || cmd == 8'd10);
  endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Loadable up-counter with terminal-count compare.
// Shared by the operand wait window and the result latency.
module alu_wait_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= count + 1'b1;
  end

  assign tc = (count == limit);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand collection and single-issue control for the ALU.
// Merges split operand beats, issues with a CE strobe, flags result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int WAIT_LIMIT = 16,
  parameter int LAT_STD    = 1,
  parameter int LAT_MUL    = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_MODE,
  input  logic [CMD_WIDTH-1:0]  REQ_CMD,
  input  logic                  REQ_CIN,
  input  logic [1:0]            REQ_INP_VALID,
  input  logic [DATA_WIDTH-1:0] REQ_OPA,
  input  logic [DATA_WIDTH-1:0] REQ_OPB,
  output logic                  CE,
  output logic                  CIN,
  output logic                  MODE,
  output logic [CMD_WIDTH-1:0]  CMD,
  output logic [1:0]            INP_VALID,
  output logic [DATA_WIDTH-1:0] OPA,
  output logic [DATA_WIDTH-1:0] OPB,
  output logic                  RES_EXP,
  output logic                  TMO
);

  localparam int TMAX_A = (WAIT_LIMIT > LAT_MUL) ? WAIT_LIMIT : LAT_MUL;
  localparam int TMAX   = (TMAX_A > LAT_STD) ? TMAX_A : LAT_STD;
  localparam int TW     = $clog2(TMAX + 1);

  issue_state_e state, state_n;

  logic                  armed;
  logic                  hold_mode;
  logic [CMD_WIDTH-1:0]  hold_cmd;
  logic                  hold_cin;
  logic [1:0]            hold_iv;
  logic [DATA_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_b;

  logic                  m_mode;
  logic [CMD_WIDTH-1:0]  m_cmd;
  logic                  m_cin;
  logic [1:0]            m_iv;
  logic [DATA_WIDTH-1:0] m_a;
  logic [DATA_WIDTH-1:0] m_b;

  need_t         need;
  logic          complete;
  logic          accept;
  logic          tc;
  logic          tmo;
  logic          lat_long;
  logic [TW-1:0] limit;

  assign REQ_READY = armed & ((state == ST_IDLE)
                   | (state == ST_WAIT)
                   | ((state == ST_BUSY) & tc));
  assign accept    = REQ_VALID & REQ_READY;

  // In WAIT the held command absorbs only the operands a beat marks valid
  always_comb begin
    m_mode = REQ_MODE;
    m_cmd  = REQ_CMD;
    m_cin  = REQ_CIN;
    m_iv   = REQ_INP_VALID;
    m_a    = REQ_OPA;
    m_b    = REQ_OPB;
    if (state == ST_WAIT) begin
      m_mode = hold_mode;
      m_cmd  = hold_cmd;
      m_cin  = hold_cin;
      m_iv   = hold_iv | (accept ? REQ_INP_VALID : 2'b00);
      m_a    = (accept & REQ_INP_VALID[0]) ? REQ_OPA : hold_a;
      m_b    = (accept & REQ_INP_VALID[1]) ? REQ_OPB : hold_b;
    end
  end

  assign need     = need_ops(m_mode, 8'(m_cmd));
  assign complete = need.invalid | ((need.mask & ~m_iv) == 2'b00);

  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept)
          state_n = complete ? ST_ISSUE : ST_WAIT;
      end
      ST_WAIT: begin
        if (accept && complete) begin
          state_n = ST_ISSUE;
        end else if (tc) begin
          state_n = ST_ISSUE;
          tmo     = 1'b1;
        end
      end
      ST_ISSUE: state_n = ST_BUSY;
      ST_BUSY: begin
        if (tc) begin
          if (accept)
            state_n = complete ? ST_ISSUE : ST_WAIT;
          else
            state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign lat_long = is_mul(MODE, 8'(CMD));

  always_comb begin
    if (state == ST_WAIT)
      limit = TW'(WAIT_LIMIT - 1);
    else if (lat_long)
      limit = TW'(LAT_MUL - 1);
    else
      limit = TW'(LAT_STD - 1);
  end

  alu_wait_timer #(
    .W(TW)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (state_n != state),
    .load_val ('0),
    .en       ((state == ST_WAIT) | (state == ST_BUSY)),
    .limit    (limit),
    .tc       (tc)
  );

  assign RES_EXP = (state == ST_BUSY) & tc;
  assign TMO     = tmo;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      hold_mode <= 1'b0;
      hold_cmd  <= '0;
      hold_cin  <= 1'b0;
      hold_iv   <= 2'b00;
      hold_a    <= '0;
      hold_b    <= '0;
      CE        <= 1'b0;
      CIN       <= 1'b0;
      MODE      <= 1'b0;
      CMD       <= '0;
      INP_VALID <= 2'b00;
      OPA       <= '0;
      OPB       <= '0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      CE    <= (state_n == ST_ISSUE);
      if (state_n == ST_WAIT) begin
        hold_mode <= m_mode;
        hold_cmd  <= m_cmd;
        hold_cin  <= m_cin;
        hold_iv   <= m_iv;
        hold_a    <= m_a;
        hold_b    <= m_b;
      end
      if (state_n == ST_ISSUE) begin
        MODE      <= m_mode;
        CMD       <= m_cmd;
        CIN       <= m_cin;
        INP_VALID <= m_iv;
        OPA       <= m_a;
        OPB       <= m_b;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomized bench for alu_issue_ctrl.
// Expectations come from a transaction-level timing model.
module tb_alu_issue_ctrl;

  localparam int WL = 16;
  localparam int LS = 1;
  localparam int LM = 2;
  localparam int WIN = 20;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_MODE;
  logic [3:0] REQ_CMD;
  logic       REQ_CIN;
  logic [1:0] REQ_INP_VALID;
  logic [7:0] REQ_OPA;
  logic [7:0] REQ_OPB;
  logic       CE;
  logic       CIN;
  logic       MODE;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [7:0] OPA;
  logic [7:0] OPB;
  logic       RES_EXP;
  logic       TMO;

  int compared = 0;
  int mismatched = 0;

  alu_issue_ctrl #(
    .DATA_WIDTH(8),
    .CMD_WIDTH (4),
    .WAIT_LIMIT(WL),
    .LAT_STD   (LS),
    .LAT_MUL   (LM)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_MODE     (REQ_MODE),
    .REQ_CMD      (REQ_CMD),
    .REQ_CIN      (REQ_CIN),
    .REQ_INP_VALID(REQ_INP_VALID),
    .REQ_OPA      (REQ_OPA),
    .REQ_OPB      (REQ_OPB),
    .CE           (CE),
    .CIN          (CIN),
    .MODE         (MODE),
    .CMD          (CMD),
    .INP_VALID    (INP_VALID),
    .OPA          (OPA),
    .OPB          (OPB),
    .RES_EXP      (RES_EXP),
    .TMO          (TMO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_need(input bit mode,
                                          input int cmd);
    if (mode) begin
      case (cmd)
        0, 1, 2, 3, 8, 9, 10: return 2'b11;
        4, 5:                 return 2'b01;
        6, 7:                 return 2'b10;
        default:              return 2'b00;
      endcase
    end
    case (cmd)
      0, 1, 2, 3, 4, 5, 12, 13: return 2'b11;
      6, 8, 9:                  return 2'b01;
      7, 10, 11:                return 2'b10;
      default:                  return 2'b00;
    endcase
  endfunction

  task automatic idle_inputs();
    REQ_VALID     = 1'b0;
    REQ_MODE      = 1'($urandom);
    REQ_CMD       = 4'($urandom);
    REQ_CIN       = 1'($urandom);
    REQ_INP_VALID = 2'($urandom);
    REQ_OPA       = 8'($urandom);
    REQ_OPB       = 8'($urandom);
  endtask

  task automatic beat(input bit mode, input bit [3:0] cmd,
                      input bit cin, input bit [1:0] iv,
                      input bit [7:0] a, input bit [7:0] b);
    REQ_VALID     = 1'b1;
    REQ_MODE      = mode;
    REQ_CMD       = cmd;
    REQ_CIN       = cin;
    REQ_INP_VALID = iv;
    REQ_OPA       = a;
    REQ_OPB       = b;
  endtask

  // gap = 0: single beat; gap = g: second beat accepted g edges later
  task automatic run_cmd(input string tag, input bit mode,
                         input bit [3:0] cmd, input bit cin,
                         input bit [1:0] iv1,
                         input bit [7:0] a1, input bit [7:0] b1,
                         input int gap, input bit [1:0] iv2,
                         input bit [7:0] a2, input bit [7:0] b2);
    logic [1:0] nd;
    logic [1:0] e_iv;
    logic [7:0] e_a, e_b;
    int e_ce, e_tmo, e_res, g;
    int ce_k, tmo_k, res_k, ce_n, tmo_n, res_n, rdy_bad;
    logic [15:0] cap_ctl;
    logic [7:0] cap_a, cap_b;
    bit exp_rdy;
    nd = ref_need(mode, int'(cmd));
    g = gap;
    e_iv = iv1; e_a = a1; e_b = b1; e_tmo = -1;
    if ((nd & ~iv1) == 2'b00) begin
      g = 0;
      e_ce = 0;
    end else begin
      if (g > 0) begin
        e_iv = iv1 | iv2;
        if (iv2[0]) e_a = a2;
        if (iv2[1]) e_b = b2;
      end
      if (g > 0 && (nd & ~e_iv) == 2'b00) begin
        e_ce = g;
      end else begin
        e_ce = WL;
        e_tmo = WL - 1;
      end
    end
    e_res = e_ce + ((mode && (cmd == 9 || cmd == 10)) ? LM : LS);
    ce_k = -1; tmo_k = -1; res_k = -1;
    ce_n = 0; tmo_n = 0; res_n = 0; rdy_bad = 0;
    cap_ctl = '0; cap_a = '0; cap_b = '0;
    @(negedge CLK);
    beat(mode, cmd, cin, iv1, a1, b1);
    #1;
    check({tag, ".rdy_accept"}, 32'(REQ_READY), 32'd1);
    for (int k = 0; k < WIN; k++) begin
      @(negedge CLK);
      idle_inputs();
      if (g > 0 && k == g - 1)
        beat(~mode, ~cmd, ~cin, iv2, a2, b2);
      #1;
      if (CE) begin
        ce_n++;
        if (ce_k < 0) begin
          ce_k = k;
          cap_ctl = {8'(MODE), 4'(CMD), 1'(CIN), 1'b0, INP_VALID};
          cap_a = OPA;
          cap_b = OPB;
        end
      end
      if (TMO) begin
        tmo_n++;
        if (tmo_k < 0) tmo_k = k;
      end
      if (RES_EXP) begin
        res_n++;
        if (res_k < 0) res_k = k;
      end
      exp_rdy = (k < e_ce) || (k >= e_res);
      if (REQ_READY !== exp_rdy) rdy_bad++;
    end
    check({tag, ".ce_cycle"}, 32'(ce_k), 32'(e_ce));
    check({tag, ".ce_count"}, 32'(ce_n), 32'd1);
    check({tag, ".tmo_cycle"}, 32'(tmo_k), 32'(e_tmo));
    check({tag, ".tmo_count"}, 32'(tmo_n), 32'((e_tmo < 0) ? 0 : 1));
    check({tag, ".res_cycle"}, 32'(res_k), 32'(e_res));
    check({tag, ".res_count"}, 32'(res_n), 32'd1);
    check({tag, ".ctl"}, 32'(cap_ctl),
          32'({8'(mode), cmd, cin, 1'b0, e_iv}));
    check({tag, ".opa"}, 32'(cap_a), 32'(e_a));
    check({tag, ".opb"}, 32'(cap_b), 32'(e_b));
    check({tag, ".ready_seq_bad"}, 32'(rdy_bad), 32'd0);
    check({tag, ".hold_opa"}, 32'(OPA), 32'(e_a));
  endtask

  initial begin
    int gap;
    bit two;
    RESET_N = 1'b0;
    idle_inputs();
    repeat (3) @(negedge CLK);
    #1;
    check("reset_outs",
          32'({REQ_READY, CE, CIN, MODE, CMD, INP_VALID,
               OPA, OPB, RES_EXP, TMO}), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    #1;
    check("ready_after_reset", 32'(REQ_READY), 32'd1);

    run_cmd("add", 1'b1, 4'd0, 1'b0, 2'b11, 8'h05, 8'h03,
            0, 2'b00, 8'h00, 8'h00);
    run_cmd("mul", 1'b1, 4'd9, 1'b1, 2'b11, 8'h12, 8'h34,
            0, 2'b00, 8'h00, 8'h00);
    run_cmd("split_and", 1'b0, 4'd0, 1'b0, 2'b01, 8'hF0, 8'hAA,
            5, 2'b10, 8'h55, 8'h0F);
    run_cmd("timeout", 1'b1, 4'd2, 1'b1, 2'b01, 8'h77, 8'h88,
            0, 2'b00, 8'h00, 8'h00);
    run_cmd("invalid_a", 1'b1, 4'd12, 1'b0, 2'b10, 8'h11, 8'h22,
            0, 2'b00, 8'h00, 8'h00);
    run_cmd("invalid_l", 1'b0, 4'd14, 1'b1, 2'b00, 8'h33, 8'h44,
            0, 2'b00, 8'h00, 8'h00);
    run_cmd("single_a", 1'b1, 4'd4, 1'b0, 2'b01, 8'h9A, 8'h00,
            0, 2'b00, 8'h00, 8'h00);
    run_cmd("limit_race", 1'b1, 4'd10, 1'b0, 2'b10, 8'h00, 8'h66,
            WL, 2'b01, 8'h5C, 8'h00);

    @(negedge CLK);
    beat(1'b0, 4'd1, 1'b0, 2'b11, 8'h3C, 8'hC3);
    @(negedge CLK);
    idle_inputs();
    #1;
    check("b2b.ce1", 32'(CE), 32'd1);
    @(negedge CLK);
    beat(1'b1, 4'd9, 1'b0, 2'b11, 8'h07, 8'h09);
    #1;
    check("b2b.res_rdy", 32'({RES_EXP, REQ_READY}), 32'b11);
    @(negedge CLK);
    idle_inputs();
    #1;
    check("b2b.ce2", 32'({CE, CMD, OPA}), 32'({1'b1, 4'd9, 8'h07}));
    @(negedge CLK);
    #1;
    check("b2b.res_early", 32'(RES_EXP), 32'd0);
    @(negedge CLK);
    #1;
    check("b2b.res_mul", 32'(RES_EXP), 32'd1);

    @(negedge CLK);
    beat(1'b1, 4'd10, 1'b1, 2'b11, 8'hA5, 8'h5A);
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rst_busy_outs",
          32'({REQ_READY, CE, CIN, MODE, CMD, INP_VALID,
               OPA, OPB, RES_EXP, TMO}), 32'd0);
    @(negedge CLK);
    #1;
    check("rst_busy_res", 32'(RES_EXP), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    #1;
    check("rst_release_rdy", 32'({REQ_READY, RES_EXP}), 32'b10);
    @(negedge CLK);
    #1;
    check("rst_release_res", 32'(RES_EXP), 32'd0);

    for (int t = 0; t < 30; t++) begin
      two = 1'($urandom);
      gap = two ? int'($urandom_range(1, WL - 1)) : 0;
      run_cmd($sformatf("rnd%0d", t), 1'($urandom),
              4'($urandom), 1'($urandom), 2'($urandom),
              8'($urandom), 8'($urandom), gap, 2'($urandom),
              8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
